// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered UART transmitter. A byte FIFO feeds a back-to-back
//               serialiser. The default frame format is 8N1. Define
//               UART_TX_PARITY_EN to build 8E1 with an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int BAUDRATE_CNT = 27_000_000 / 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int c_BW = (BAUDRATE_CNT > 1) ? $clog2(BAUDRATE_CNT) : 1;
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUDRATE_CNT - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL  = c_CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [c_BW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [c_PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0]   count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_last;
    logic [7:0]        w_head;

    assign w_full      = (count_q == c_CNT_FULL);
    assign w_empty     = (count_q == '0);
    assign w_push      = tx_valid && !w_full;
    assign w_baud_last = (baud_cnt_q == c_BAUD_LAST);
    assign w_head      = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = w_baud_last ? '0 : baud_cnt_q + c_BAUD_ONE;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (tx_valid & w_full);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        w_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                w_pop      = !w_empty;
            end
            ST_START: begin
                if (w_baud_last) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_last) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_last) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A pop chains straight into a start bit, so back-to-back frames
        // leave no idle cycle between stop and start.
        if (w_pop) begin
            state_d    = ST_START;
            shift_d    = w_head;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            baud_cnt_d = '0;
            rd_ptr_d   = rd_ptr_q + c_PTR_ONE;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^w_head;
`endif
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: reset clears the pointers, so old entries are unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_ready   = !w_full;
    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo. A line monitor decodes the
//               frames and compares each one with the queued bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_BAUD  = 4;
    localparam int c_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int c_NB    = 11;
`else
    localparam int c_NB    = 10;
`endif
    localparam int c_FRAME = c_NB * c_BAUD;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];
    bit         mon_active = 1'b0;

    uart_tx_fifo #(
        .BAUDRATE_CNT (c_BAUD),
        .FIFO_DEPTH   (c_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit accept, output int e);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        e = cyc;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic wait_cyc(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
        if (cyc != target) check("wait_cyc_overrun", cyc, target);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (busy == 1'b0) && (fifo_count == 3'd0) && !mon_active;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Line monitor: samples mid-bit, compares whole frames against the scoreboard.
    initial begin : line_monitor
        int               cnt;
        logic [c_NB-1:0]  bits;
        logic [c_NB-1:0]  expf;
        logic [7:0]       exp_b;
        cnt  = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (uart_tx == 1'b0) begin
                    mon_active = 1'b1;
                    cnt        = 0;
                    bits       = '0;
                    starts_q.push_back(cyc);
                end
            end else begin
                cnt++;
            end
            if (mon_active && !rst && (cnt % c_BAUD) == c_BAUD / 2) begin
                bits[cnt / c_BAUD] = uart_tx;
                if (cnt / c_BAUD == c_NB - 1) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("extra_frame", {24'h0, bits[8:1]}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        for (int i = 0; i < c_NB; i++) expf[i] = frame_bit(exp_b, i);
                        check("frame", bits, expf);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e0, e1, e2, n;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte, bit-exact waveform and latency
        starts_q.delete();
        push_byte(8'hA5, 1'b1, e0);
        @(negedge clk);
        check("t1_line_before_start", uart_tx, 1);
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            check($sformatf("t1_bit%0d", i / c_BAUD), uart_tx, frame_bit(8'hA5, i / c_BAUD));
            check("t1_busy", busy, 1);
        end
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_line_idle", uart_tx, 1);
        check("t1_nstarts", starts_q.size(), 1);
        if (starts_q.size() >= 1) check("t1_latency", starts_q[0], e0 + 1);
        wait_idle(200);

        // 2: burst of three with no inter-frame gap
        starts_q.delete();
        push_byte(8'h55, 1'b1, e0);
        check("t2_count1", fifo_count, 1);
        push_byte(8'h0F, 1'b1, e1);
        check("t2_count2", fifo_count, 1);
        push_byte(8'hF0, 1'b1, e2);
        check("t2_count3", fifo_count, 2);
        wait_idle(3 * c_FRAME + 50);
        check("t2_nstarts", starts_q.size(), 3);
        if (starts_q.size() >= 3) begin
            check("t2_gap1", starts_q[1] - starts_q[0], c_FRAME);
            check("t2_gap2", starts_q[2] - starts_q[1], c_FRAME);
        end
        check("t2_count_end", fifo_count, 0);

        // 3: fill past full; sixth byte dropped, overflow sticky
        for (int i = 0; i < 5; i++) push_byte(8'h11 * (i + 1), 1'b1, e0);
        check("t3_ready_low", tx_ready, 0);
        check("t3_count_full", fifo_count, 4);
        check("t3_ovf_before", overflow, 0);
        push_byte(8'hEE, 1'b0, e0);
        check("t3_ovf_set", overflow, 1);
        check("t3_count_after_drop", fifo_count, 4);
        wait_idle(5 * c_FRAME + 50);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_ready_high", tx_ready, 1);

        // 4: asynchronous reset in the middle of a frame
        push_byte(8'h00, 1'b1, e0);
        push_byte(8'h3C, 1'b1, e1);
        push_byte(8'hC3, 1'b1, e2);
        repeat (c_BAUD + 3) @(negedge clk);
        check("t4_busy_pre", busy, 1);
        check("t4_count_pre", fifo_count, 2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t4_uart_tx", uart_tx, 1);
        check("t4_count", fifo_count, 0);
        check("t4_busy", busy, 0);
        check("t4_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = starts_q.size();
        repeat (3 * c_FRAME) @(negedge clk);
        check("t4_silent", starts_q.size(), n);
        check("t4_line_idle", uart_tx, 1);

        // 5: push on the last STOP cycle with an empty FIFO
        starts_q.delete();
        push_byte(8'h96, 1'b1, e0);
        wait_cyc(e0 + c_FRAME - 1);
        push_byte(8'h69, 1'b1, e1);
        @(negedge clk);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_line", uart_tx, 1);
        check("t5_idle_count", fifo_count, 1);
        @(negedge clk);
        check("t5_start_busy", busy, 1);
        check("t5_start_line", uart_tx, 0);
        check("t5_start_count", fifo_count, 0);
        wait_idle(2 * c_FRAME + 50);
        check("t5_nstarts", starts_q.size(), 2);
        if (starts_q.size() >= 2) check("t5_gap", starts_q[1] - starts_q[0], c_FRAME + 1);

`ifdef UART_TX_PARITY_EN
        // 6: even parity bit and 11-bit frame length
        starts_q.delete();
        push_byte(8'h07, 1'b1, e0);
        push_byte(8'h03, 1'b1, e1);
        wait_cyc(e0 + 1 + 9 * c_BAUD + c_BAUD / 2);
        check("t6_parity_07", uart_tx, 1);
        wait_cyc(e0 + 1 + c_FRAME + 9 * c_BAUD + c_BAUD / 2);
        check("t6_parity_03", uart_tx, 0);
        wait_idle(2 * c_FRAME + 50);
        check("t6_nstarts", starts_q.size(), 2);
        if (starts_q.size() >= 2) check("t6_frame_len", starts_q[1] - starts_q[0], 44);
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
